// File: rtl/load_store_unit_pkg.sv
// Shared instruction constants for the load/store path: decoded op, FSM states, access sizes.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

    typedef struct packed {
        logic lw;
        logic lh;
        logic lhu;
        logic lb;
        logic lbu;
        logic sw;
        logic sh;
        logic sb;
    } InstructionSet;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } lsu_state_e;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } access_size_e;

    function automatic logic is_aligned(input access_size_e size, input logic [1:0] addr_lo);
        case (size)
            WORD:    is_aligned = (addr_lo == 2'b00);
            HALF:    is_aligned = (addr_lo[0] == 1'b0);
            default: is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane enables, store-data replication and load-data extraction/extension.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  access_size_e size,
    input  logic [1:0]   addr_lo,
    input  logic         sign_ext,
    input  logic [31:0]  wdata,
    input  logic [31:0]  mem_rdata,
    output logic [3:0]   be,
    output logic [31:0]  wdata_rep,
    output logic [31:0]  rdata_ext
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = mem_rdata >> {addr_lo, 3'b000};
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = mem_rdata;
        case (size)
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between the pipeline and a word-wide memory port.
// Latency: start -> mem_req next cycle -> done the cycle after ack; misaligned ops fault in 1 cycle.
// Backpressure: busy stalls the pipeline; mem_req is held until mem_ack with no timeout.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  InstructionSet op,
    input  logic          start,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic [31:0]   rdata,
    output logic          fault,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    lsu_state_e   state_q, state_d;
    access_size_e size_q, req_size;
    logic [1:0]   lo_q;
    logic         sign_q, we_q, fault_q;
    logic [29:0]  addr_q;
    logic [31:0]  wdata_q, rdata_q;
    logic         req_vld, req_we, req_sign, req_aligned, accept;
    logic [3:0]   be;
    logic [31:0]  wdata_rep, rdata_ext;

    // Priority encode the one-hot op; loads win over stores, wider over narrower.
    always_comb begin
        req_vld  = 1'b1;
        req_we   = 1'b0;
        req_sign = 1'b0;
        req_size = WORD;
        if (op.lw) begin
            req_size = WORD;
        end else if (op.lh) begin
            req_size = HALF;
            req_sign = 1'b1;
        end else if (op.lhu) begin
            req_size = HALF;
        end else if (op.lb) begin
            req_size = BYTE;
            req_sign = 1'b1;
        end else if (op.lbu) begin
            req_size = BYTE;
        end else if (op.sw) begin
            req_we   = 1'b1;
        end else if (op.sh) begin
            req_we   = 1'b1;
            req_size = HALF;
        end else if (op.sb) begin
            req_we   = 1'b1;
            req_size = BYTE;
        end else begin
            req_vld  = 1'b0;
        end
    end

    assign req_aligned = is_aligned(req_size, addr[1:0]);
    assign accept      = (state_q == IDLE) && start && req_vld;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_aligned ? REQ : DONE;
            REQ:     if (mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= BYTE;
            lo_q    <= 2'b00;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                size_q  <= req_size;
                lo_q    <= addr[1:0];
                sign_q  <= req_sign;
                we_q    <= req_we;
                addr_q  <= addr[31:2];
                wdata_q <= wdata;
                rdata_q <= '0;
                fault_q <= !req_aligned;
            end else if (state_q == REQ && mem_ack) begin
                rdata_q <= we_q ? 32'h0 : rdata_ext;
            end
        end
    end

    // Lane logic works from latched request fields so the bus stays stable while waiting.
    lsu_lane_align u_align (
        .size      (size_q),
        .addr_lo   (lo_q),
        .sign_ext  (sign_q),
        .wdata     (wdata_q),
        .mem_rdata (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rdata     = done ? rdata_q : 32'h0;
    assign fault     = done & fault_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? {addr_q, 2'b00} : 32'h0;
    assign mem_be    = mem_req ? be : 4'h0;
    assign mem_wdata = (mem_req && we_q) ? wdata_rep : 32'h0;

endmodule
